gpio_port_pcint: RTL and testbench

//  Parametrised GPIO port (PINx/DDRx/PORTx) for the ATmega328PB-compatible I/O space, extended with pin-change interrupt logic.

---
 rtl/gpio_pkg.sv | 31 +++
 rtl/gpio_sync_edge.sv | 56 +++++
 rtl/gpio_port_pcint.sv | 205 ++++++++++++++++++++
 tb/tb_gpio_port_pcint.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the pin-change-interrupt GPIO port.
//   impl_mask()    : 8-bit mask with the low 'width' bits set (implemented port bits)
//   PCIE_BIT/PCIF_BIT : bit positions inside the PCCTL control/status register
//   *_ADDR_DEF     : default I/O addresses of the six port registers
package gpio_pkg;

    localparam int PCIE_BIT = 0;
    localparam int PCIF_BIT = 1;

    localparam logic [5:0] PINX_ADDR_DEF  = 6'h03;
    localparam logic [5:0] DDRX_ADDR_DEF  = 6'h04;
    localparam logic [5:0] PORTX_ADDR_DEF = 6'h05;
    localparam logic [5:0] PCMSK_ADDR_DEF = 6'h06;
    localparam logic [5:0] PCCTL_ADDR_DEF = 6'h07;
    localparam logic [5:0] PCCHG_ADDR_DEF = 6'h08;

    // Mask of the implemented bits for a port of the given width (1..8).
    function automatic logic [7:0] impl_mask(input int width);
        logic [7:0] m;
        m = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (i < width) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Pad-input synchroniser with change detection and post-reset warm-up.
//   clk       : system clock (rising edge)
//   ireset    : synchronous active-high reset
//   pin_async : asynchronous pad inputs
//   sync_s    : synchronised pin values (last stage of the chain)
//   chg_raw_s : bits whose synchronised value differs from the previous cycle
//   warm_s    : high once the chain has been filled with real pad data, so
//               the reset-to-pad-level transition is not mistaken for a change
module gpio_sync_edge
    import gpio_pkg::*;
#(
    parameter int port_width  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  ireset,
    input  logic [port_width-1:0] pin_async,
    output logic [port_width-1:0] sync_s,
    output logic [port_width-1:0] chg_raw_s,
    output logic                  warm_s
);

    localparam int              CNT_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] WARM_MAX = CNT_W'(SYNC_STAGES + 1);

    logic [port_width-1:0] sync_chain_r [SYNC_STAGES];
    logic [port_width-1:0] prev_r;
    logic [CNT_W-1:0]      warm_cnt_r;

    // Synchroniser chain, previous-value register and saturating warm-up counter.
    always_ff @(posedge clk) begin
        if (ireset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_chain_r[i] <= '0;
            end
            prev_r     <= '0;
            warm_cnt_r <= '0;
        end else begin
            sync_chain_r[0] <= pin_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_chain_r[i] <= sync_chain_r[i-1];
            end
            prev_r <= sync_chain_r[SYNC_STAGES-1];
            if (warm_cnt_r != WARM_MAX) begin
                warm_cnt_r <= warm_cnt_r + 1'b1;
            end else begin
                warm_cnt_r <= warm_cnt_r;
            end
        end
    end

    assign sync_s    = sync_chain_r[SYNC_STAGES-1];
    assign chg_raw_s = sync_chain_r[SYNC_STAGES-1] ^ prev_r;
    assign warm_s    = (warm_cnt_r == WARM_MAX);

endmodule

// File: rtl/gpio_port_pcint.sv
// GPIO port (PINx/DDRx/PORTx) with pin-change interrupt on the 6-bit I/O bus.
//   cp2       : system clock          ireset  : synchronous active-high reset
//   IO_Addr   : I/O address           iore/iowe : read / write strobes
//   dbus_in   : write data            dbus_out : read data (combinational)
//   out_en    : read hit (combinational)
//   portx/ddrx: PORTx / DDRx registers
//   pinx      : asynchronous pad inputs
//   irq       : level interrupt request (PCIF & PCIE)
//   irq_ack   : one-cycle acknowledge, clears PCIF and the capture register
module gpio_port_pcint
    import gpio_pkg::*;
#(
    parameter logic [5:0] PINx_Address  = PINX_ADDR_DEF,
    parameter logic [5:0] DDRx_Address  = DDRX_ADDR_DEF,
    parameter logic [5:0] PORTx_Address = PORTX_ADDR_DEF,
    parameter logic [5:0] PCMSK_Address = PCMSK_ADDR_DEF,
    parameter logic [5:0] PCCTL_Address = PCCTL_ADDR_DEF,
    parameter logic [5:0] PCCHG_Address = PCCHG_ADDR_DEF,
    parameter int         port_width    = 8,
    parameter int         SYNC_STAGES   = 2,
    parameter logic [7:0] RST_PORT      = 8'h00,
    parameter logic [7:0] RST_DDR       = 8'h00
) (
    input  logic                  cp2,
    input  logic                  ireset,
    input  logic [5:0]            IO_Addr,
    input  logic                  iore,
    input  logic                  iowe,
    input  logic [7:0]            dbus_in,
    output logic [7:0]            dbus_out,
    output logic                  out_en,
    output logic [port_width-1:0] portx,
    output logic [port_width-1:0] ddrx,
    input  logic [port_width-1:0] pinx,
    output logic                  irq,
    input  logic                  irq_ack
);

    localparam logic [7:0]            IMPL_MASK  = impl_mask(port_width);
    localparam logic [7:0]            RST_PORT_8 = RST_PORT & IMPL_MASK;
    localparam logic [7:0]            RST_DDR_8  = RST_DDR & IMPL_MASK;
    localparam logic [port_width-1:0] RST_PORT_M = RST_PORT_8[port_width-1:0];
    localparam logic [port_width-1:0] RST_DDR_M  = RST_DDR_8[port_width-1:0];

    logic [port_width-1:0] port_r;
    logic [port_width-1:0] ddr_r;
    logic [port_width-1:0] pcmsk_r;
    logic [port_width-1:0] pcchg_r;
    logic                  pcie_r;
    logic                  pcif_r;

    logic [7:0]            wr_data8_s;
    logic [port_width-1:0] wr_data_s;
    logic                  wr_pin_s;
    logic                  wr_ddr_s;
    logic                  wr_port_s;
    logic                  wr_pcmsk_s;
    logic                  wr_pcctl_s;

    logic [port_width-1:0] sync_s;
    logic [port_width-1:0] chg_raw_s;
    logic                  warm_s;
    logic [port_width-1:0] chg_s;
    logic                  event_s;
    logic                  clear_s;
    logic                  pcif_nxt_s;
    logic [port_width-1:0] pcchg_nxt_s;

    logic [7:0]            rd_data_s;
    logic                  rd_hit_s;

    gpio_sync_edge #(
        .port_width  (port_width),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk       (cp2),
        .ireset    (ireset),
        .pin_async (pinx),
        .sync_s    (sync_s),
        .chg_raw_s (chg_raw_s),
        .warm_s    (warm_s)
    );

    assign wr_data8_s = dbus_in & IMPL_MASK;
    assign wr_data_s  = wr_data8_s[port_width-1:0];
    assign wr_pin_s   = iowe && (IO_Addr == PINx_Address);
    assign wr_ddr_s   = iowe && (IO_Addr == DDRx_Address);
    assign wr_port_s  = iowe && (IO_Addr == PORTx_Address);
    assign wr_pcmsk_s = iowe && (IO_Addr == PCMSK_Address);
    assign wr_pcctl_s = iowe && (IO_Addr == PCCTL_Address);

    // A mask change alters chg_s only through the AND; it never creates a
    // transition in chg_raw_s, so it cannot raise an event by itself.
    assign chg_s   = chg_raw_s & pcmsk_r;
    assign event_s = warm_s && (|chg_s);
    assign clear_s = (wr_pcctl_s && dbus_in[PCIF_BIT]) || irq_ack;

    // Flag/capture next state: a new event beats a simultaneous clear, and in
    // that case the capture holds only the bits that changed this cycle.
    always_comb begin
        pcif_nxt_s  = pcif_r;
        pcchg_nxt_s = pcchg_r;
        if (event_s) begin
            pcif_nxt_s = 1'b1;
            if (clear_s) begin
                pcchg_nxt_s = chg_s;
            end else begin
                pcchg_nxt_s = pcchg_r | chg_s;
            end
        end else if (clear_s) begin
            pcif_nxt_s  = 1'b0;
            pcchg_nxt_s = '0;
        end else begin
            pcif_nxt_s  = pcif_r;
            pcchg_nxt_s = pcchg_r;
        end
    end

    // Port data/direction registers; a PINx write toggles the selected PORTx bits.
    always_ff @(posedge cp2) begin
        if (ireset) begin
            port_r <= RST_PORT_M;
            ddr_r  <= RST_DDR_M;
        end else begin
            if (wr_port_s) begin
                port_r <= wr_data_s;
            end else if (wr_pin_s) begin
                port_r <= port_r ^ wr_data_s;
            end else begin
                port_r <= port_r;
            end
            if (wr_ddr_s) begin
                ddr_r <= wr_data_s;
            end else begin
                ddr_r <= ddr_r;
            end
        end
    end

    // Pin-change mask, enable, flag and capture registers.
    always_ff @(posedge cp2) begin
        if (ireset) begin
            pcmsk_r <= '0;
            pcie_r  <= 1'b0;
            pcif_r  <= 1'b0;
            pcchg_r <= '0;
        end else begin
            if (wr_pcmsk_s) begin
                pcmsk_r <= wr_data_s;
            end else begin
                pcmsk_r <= pcmsk_r;
            end
            if (wr_pcctl_s) begin
                pcie_r <= dbus_in[PCIE_BIT];
            end else begin
                pcie_r <= pcie_r;
            end
            pcif_r  <= pcif_nxt_s;
            pcchg_r <= pcchg_nxt_s;
        end
    end

    // Read mux; narrower registers are zero-extended to the 8-bit bus.
    always_comb begin
        rd_data_s = 8'h00;
        rd_hit_s  = 1'b0;
        case (IO_Addr)
            PINx_Address: begin
                rd_data_s = 8'(sync_s);
                rd_hit_s  = 1'b1;
            end
            DDRx_Address: begin
                rd_data_s = 8'(ddr_r);
                rd_hit_s  = 1'b1;
            end
            PORTx_Address: begin
                rd_data_s = 8'(port_r);
                rd_hit_s  = 1'b1;
            end
            PCMSK_Address: begin
                rd_data_s = 8'(pcmsk_r);
                rd_hit_s  = 1'b1;
            end
            PCCTL_Address: begin
                rd_data_s = {6'b000000, pcif_r, pcie_r};
                rd_hit_s  = 1'b1;
            end
            PCCHG_Address: begin
                rd_data_s = 8'(pcchg_r);
                rd_hit_s  = 1'b1;
            end
            default: begin
                rd_data_s = 8'h00;
                rd_hit_s  = 1'b0;
            end
        endcase
    end

    assign dbus_out = rd_data_s;
    assign out_en   = rd_hit_s && iore;
    assign portx    = port_r;
    assign ddrx     = ddr_r;
    assign irq      = pcif_r && pcie_r;

endmodule

// File: tb/tb_gpio_port_pcint.sv
// Scoreboard bench for gpio_port_pcint: an 8-bit instance (RST_PORT=A5) and a
// 3-bit instance share the I/O bus. Each read pushes its expected response;
// a negedge monitor pops and compares whenever a read strobe is presented.
module tb_gpio_port_pcint;

    localparam logic [5:0] A_PIN   = 6'h03;
    localparam logic [5:0] A_DDR   = 6'h04;
    localparam logic [5:0] A_PORT  = 6'h05;
    localparam logic [5:0] A_PCMSK = 6'h06;
    localparam logic [5:0] A_PCCTL = 6'h07;
    localparam logic [5:0] A_PCCHG = 6'h08;
    localparam logic [5:0] A_NONE  = 6'h2A;

    typedef struct {
        int         inst;
        string      name;
        logic [7:0] data;
        logic       oe;
        logic       chk_irq;
        logic       irq;
    } exp_t;

    logic       cp2;
    logic       ireset;
    logic [5:0] IO_Addr;
    logic       iore;
    logic       iowe;
    logic [7:0] dbus_in;
    logic       irq_ack;

    logic [7:0] dbus_out_a;
    logic       out_en_a;
    logic [7:0] portx_a;
    logic [7:0] ddrx_a;
    logic [7:0] pins_a;
    logic       irq_a;

    logic [7:0] dbus_out_b;
    logic       out_en_b;
    logic [2:0] portx_b;
    logic [2:0] ddrx_b;
    logic [2:0] pins_b;
    logic       irq_b;

    exp_t exp_q[$];
    exp_t e;
    int   errors;
    int   checks;
    logic final_req;
    logic final_done;
    logic [7:0] got_d;
    logic       got_oe;
    logic       got_irq;

    gpio_port_pcint #(
        .port_width (8),
        .RST_PORT   (8'hA5)
    ) dut_a (
        .cp2      (cp2),
        .ireset   (ireset),
        .IO_Addr  (IO_Addr),
        .iore     (iore),
        .iowe     (iowe),
        .dbus_in  (dbus_in),
        .dbus_out (dbus_out_a),
        .out_en   (out_en_a),
        .portx    (portx_a),
        .ddrx     (ddrx_a),
        .pinx     (pins_a),
        .irq      (irq_a),
        .irq_ack  (irq_ack)
    );

    gpio_port_pcint #(
        .port_width (3)
    ) dut_b (
        .cp2      (cp2),
        .ireset   (ireset),
        .IO_Addr  (IO_Addr),
        .iore     (iore),
        .iowe     (iowe),
        .dbus_in  (dbus_in),
        .dbus_out (dbus_out_b),
        .out_en   (out_en_b),
        .portx    (portx_b),
        .ddrx     (ddrx_b),
        .pinx     (pins_b),
        .irq      (irq_b),
        .irq_ack  (irq_ack)
    );

    initial begin
        cp2 = 1'b0;
        forever #5 cp2 = ~cp2;
    end

    // Monitor: compare every presented read against the head of the scoreboard.
    always @(negedge cp2) begin
        if (iore) begin
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                checks = checks + 1;
                $display("FAIL unexpected_read: addr=%h with empty scoreboard, required an entry", IO_Addr);
            end else begin
                e = exp_q.pop_front();
                if (e.inst == 0) begin
                    got_d = dbus_out_a; got_oe = out_en_a; got_irq = irq_a;
                end else begin
                    got_d = dbus_out_b; got_oe = out_en_b; got_irq = irq_b;
                end
                checks = checks + 1;
                if (got_d !== e.data || got_oe !== e.oe) begin
                    errors = errors + 1;
                    $display("FAIL %s: dbus_out=%h out_en=%b, required dbus_out=%h out_en=%b",
                             e.name, got_d, got_oe, e.data, e.oe);
                end
                if (e.chk_irq) begin
                    checks = checks + 1;
                    if (got_irq !== e.irq) begin
                        errors = errors + 1;
                        $display("FAIL %s_irq: irq=%b, required %b", e.name, got_irq, e.irq);
                    end
                end
            end
        end
        if (final_req && !final_done) begin
            final_done = 1'b1;
            checks = checks + 1;
            if (exp_q.size() != 0) begin
                errors = errors + 1;
                $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge cp2);
            #1;
        end
    endtask

    task automatic wr(input logic [5:0] addr, input logic [7:0] data);
        IO_Addr = addr;
        dbus_in = data;
        iowe    = 1'b1;
        @(posedge cp2);
        #1;
        iowe    = 1'b0;
    endtask

    task automatic rd(input int inst, input logic [5:0] addr, input logic [7:0] data,
                      input string name, input logic chk_irq = 1'b0,
                      input logic irq_exp = 1'b0, input logic oe = 1'b1);
        exp_t x;
        x.inst    = inst;
        x.name    = name;
        x.data    = data;
        x.oe      = oe;
        x.chk_irq = chk_irq;
        x.irq     = irq_exp;
        exp_q.push_back(x);
        IO_Addr = addr;
        iore    = 1'b1;
        @(posedge cp2);
        #1;
        iore    = 1'b0;
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        @(posedge cp2);
        #1;
        irq_ack = 1'b0;
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        final_req  = 1'b0;
        final_done = 1'b0;
        ireset     = 1'b1;
        IO_Addr    = 6'h00;
        iore       = 1'b0;
        iowe       = 1'b0;
        dbus_in    = 8'h00;
        irq_ack    = 1'b0;
        pins_a     = 8'hFF;
        pins_b     = 3'b000;
        @(posedge cp2);
        #1;
        ireset = 1'b0;

        // Reset state; pins held high through warm-up must not flag
        rd(0, A_PCCTL, 8'h00, "rst_pcctl", 1'b1, 1'b0);
        wr(A_PCMSK, 8'hFF);
        wr(A_PCCTL, 8'h01);
        rd(0, A_PORT,  8'hA5, "rst_portx");
        rd(0, A_DDR,   8'h00, "rst_ddrx");
        rd(0, A_PCCTL, 8'h01, "warmup_no_pcif", 1'b1, 1'b0);
        rd(0, A_PIN,   8'hFF, "rst_pinx");

        // PINx write toggles PORTx
        wr(A_PORT, 8'h0F);
        wr(A_PIN,  8'hFF);
        rd(0, A_PORT, 8'hF0, "toggle_ff");
        wr(A_PIN,  8'h00);
        rd(0, A_PORT, 8'hF0, "toggle_00");

        // Latency: sync after 2 edges, flag after 3
        wr(A_PCMSK, 8'h00);
        pins_a = 8'h00;
        idle(5);
        wr(A_PCMSK, 8'h01);
        pins_a = 8'h01;
        rd(0, A_PIN,   8'h00, "lat_pin_e1");
        rd(0, A_PIN,   8'h00, "lat_pin_e2");
        rd(0, A_PIN,   8'h01, "lat_pin_after_e2", 1'b1, 1'b0);
        rd(0, A_PCCTL, 8'h03, "lat_pcif_after_e3", 1'b1, 1'b1);
        rd(0, A_PCCHG, 8'h01, "lat_pcchg");
        ack();
        rd(0, A_PCCTL, 8'h01, "ack_pcctl", 1'b1, 1'b0);
        rd(0, A_PCCHG, 8'h00, "ack_pcchg");

        // Masked-off bits never flag
        wr(A_PCMSK, 8'h02);
        pins_a = 8'h00;
        idle(4);
        pins_a = 8'h05;
        idle(4);
        rd(0, A_PCCTL, 8'h01, "mask_no_pcif", 1'b1, 1'b0);
        rd(0, A_PIN,   8'h05, "mask_pinx");

        // Set/clear race: ack in the same cycle as a new bit1 change
        wr(A_PCMSK, 8'h03);
        pins_a = 8'h04;
        idle(4);
        rd(0, A_PCCHG, 8'h01, "race_pre_pcchg", 1'b1, 1'b1);
        pins_a = 8'h06;
        idle(2);
        ack();
        rd(0, A_PCCTL, 8'h03, "race_pcif", 1'b1, 1'b1);
        rd(0, A_PCCHG, 8'h02, "race_pcchg");

        // Write-1-to-clear through PCCTL, then PCIE=0 masks irq only
        wr(A_PCCTL, 8'h03);
        rd(0, A_PCCTL, 8'h01, "w1c_pcctl", 1'b1, 1'b0);
        rd(0, A_PCCHG, 8'h00, "w1c_pcchg");
        wr(A_PCCTL, 8'h00);
        pins_a = 8'h04;
        idle(4);
        rd(0, A_PCCTL, 8'h02, "pcie0_pcif", 1'b1, 1'b0);
        wr(A_PCCTL, 8'h02);
        rd(0, A_PCCTL, 8'h00, "pcie0_clear");

        // 3-bit instance: unimplemented bits read 0; unmapped address misses
        wr(A_PORT,  8'hFF);
        wr(A_DDR,   8'hFF);
        wr(A_PCMSK, 8'hFF);
        rd(1, A_PORT,  8'h07, "w3_portx");
        rd(1, A_DDR,   8'h07, "w3_ddrx");
        rd(1, A_PCMSK, 8'h07, "w3_pcmsk");
        rd(1, A_PIN,   8'h00, "w3_pinx");
        rd(1, A_NONE,  8'h00, "w3_unmapped", 1'b0, 1'b0, 1'b0);
        rd(0, A_NONE,  8'h00, "w8_unmapped", 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a pending event
        wr(A_PCCTL, 8'h01);
        pins_a = 8'h05;
        idle(1);
        ireset = 1'b1;
        idle(1);
        ireset = 1'b0;
        idle(4);
        rd(0, A_PCCTL, 8'h00, "midrst_pcctl", 1'b1, 1'b0);
        rd(0, A_PCCHG, 8'h00, "midrst_pcchg");
        rd(0, A_PORT,  8'hA5, "midrst_portx");

        final_req = 1'b1;
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
